// File: rtl/serial_shift_driver.sv
// Serial shift-out engine for 74HC595-style chains: clear, shift WIDTH bits on a divided
// sclk, latch via pen, then signal done. Supports one pending request and auto-refresh.
module serial_shift_driver #(
  parameter int WIDTH        = 16,
  parameter int DIV          = 4,
  parameter int LSB_FIRST    = 0,
  parameter int AUTO_REFRESH = 1,
  parameter int REFRESH_GAP  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pdata,
  input  logic             load,
  output logic             ready,
  output logic             done,
  output logic             sclk,
  output logic             sdo,
  output logic             pen,
  output logic             clr_n
);

  localparam int CW = $clog2(2 * DIV);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(REFRESH_GAP - 1);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [BW-1:0]    bit_reg, bit_next;
  logic [GW-1:0]    idle_reg, idle_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic             pending_reg, pending_next;
  logic             sclk_reg, sdo_reg, pen_reg, clr_n_reg, ready_reg, done_reg;
  logic             sclk_next, sdo_next, pen_next, clr_n_next, ready_next, done_next;
  logic             phase_end, refresh_fire, start;
  logic [WIDTH-1:0] pdata_ord;
  logic [WIDTH-1:0] shadow_shifted;

  // The shadow is stored in transmit order so bit k of the frame is always shadow[k].
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
    assign pdata_ord[gi] = (LSB_FIRST != 0) ? pdata[gi] : pdata[WIDTH-1-gi];
  end

  // The done cycle itself is not an idle cycle, so the refresh gap is measured after it.
  assign refresh_fire = (AUTO_REFRESH != 0) && !done_reg && (idle_reg == GAP_LAST);
  assign start        = load || pending_reg || refresh_fire;
  assign phase_end    = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      idle_reg    <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      sclk_reg    <= 1'b0;
      sdo_reg     <= 1'b0;
      pen_reg     <= 1'b0;
      clr_n_reg   <= 1'b0;
      ready_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      idle_reg    <= idle_next;
      shadow_reg  <= shadow_next;
      pending_reg <= pending_next;
      sclk_reg    <= sclk_next;
      sdo_reg     <= sdo_next;
      pen_reg     <= pen_next;
      clr_n_reg   <= clr_n_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    idle_next    = '0;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    case (state_reg)
      ST_CLEAR: begin
        pending_next = pending_reg || load;
        if (phase_end) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_SHIFT;
          cnt_next     = '0;
          bit_next     = '0;
          shadow_next  = pdata_ord;
          pending_next = 1'b0;
        end else if (!done_reg) begin
          idle_next = idle_reg + GW'(1);
        end
      end
      ST_SHIFT: begin
        pending_next = pending_reg || load;
        if (phase_end) begin
          cnt_next = '0;
          if (bit_reg == BIT_LAST) begin
            state_next = ST_LATCH;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        pending_next = pending_reg || load;
        if (phase_end) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    endcase
  end

  // Outputs are decoded from the next-state values so the registered pins line up with the state.
  always_comb begin
    shadow_shifted = shadow_next >> bit_next;
    sclk_next      = (state_next == ST_SHIFT) && (cnt_next >= CNT_HIGH);
    sdo_next       = (state_next == ST_SHIFT) && shadow_shifted[0];
    pen_next       = (state_next == ST_LATCH);
    clr_n_next     = (state_next != ST_CLEAR);
    ready_next     = (state_next == ST_IDLE) && !pending_next;
    done_next      = (state_reg == ST_LATCH) && (state_next == ST_IDLE);
  end

  assign sclk  = sclk_reg;
  assign sdo   = sdo_reg;
  assign pen   = pen_reg;
  assign clr_n = clr_n_reg;
  assign ready = ready_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_serial_shift_driver.sv
// Directed bench for serial_shift_driver: four instances cover MSB/LSB order, auto-refresh
// and the 1-bit/DIV=1 corner; table vectors plus hand-written multi-cycle sequences.
module tb_serial_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // a: W8 D2 MSB-first, b: LSB-first, c: auto-refresh gap 10, d: W1 D1
  logic       rst_a, load_a, ready_a, done_a, sclk_a, sdo_a, pen_a, clr_n_a;
  logic       rst_b, load_b, ready_b, done_b, sclk_b, sdo_b, pen_b, clr_n_b;
  logic       rst_c, load_c, ready_c, done_c, sclk_c, sdo_c, pen_c, clr_n_c;
  logic       rst_d, load_d, ready_d, done_d, sclk_d, sdo_d, pen_d, clr_n_d;
  logic [7:0] pdata_a, pdata_b, pdata_c;
  logic [0:0] pdata_d;

  serial_shift_driver #(.WIDTH(8), .DIV(2), .LSB_FIRST(0), .AUTO_REFRESH(0), .REFRESH_GAP(256)) u_a (
    .clk(clk), .rst(rst_a), .pdata(pdata_a), .load(load_a), .ready(ready_a), .done(done_a),
    .sclk(sclk_a), .sdo(sdo_a), .pen(pen_a), .clr_n(clr_n_a));
  serial_shift_driver #(.WIDTH(8), .DIV(2), .LSB_FIRST(1), .AUTO_REFRESH(0), .REFRESH_GAP(256)) u_b (
    .clk(clk), .rst(rst_b), .pdata(pdata_b), .load(load_b), .ready(ready_b), .done(done_b),
    .sclk(sclk_b), .sdo(sdo_b), .pen(pen_b), .clr_n(clr_n_b));
  serial_shift_driver #(.WIDTH(8), .DIV(2), .LSB_FIRST(0), .AUTO_REFRESH(1), .REFRESH_GAP(10)) u_c (
    .clk(clk), .rst(rst_c), .pdata(pdata_c), .load(load_c), .ready(ready_c), .done(done_c),
    .sclk(sclk_c), .sdo(sdo_c), .pen(pen_c), .clr_n(clr_n_c));
  serial_shift_driver #(.WIDTH(1), .DIV(1), .LSB_FIRST(0), .AUTO_REFRESH(0), .REFRESH_GAP(256)) u_d (
    .clk(clk), .rst(rst_d), .pdata(pdata_d), .load(load_d), .ready(ready_d), .done(done_d),
    .sclk(sclk_d), .sdo(sdo_d), .pen(pen_d), .clr_n(clr_n_d));

  // Monitors: sdo captured at each observed sclk rise, done pulses logged with cycle number.
  logic bits_a[$], bits_b[$], bits_c[$];
  int   done_cyc_a[$], done_cyc_b[$], done_cyc_c[$];
  logic sclk_a_q = 1'b0, sclk_b_q = 1'b0, sclk_c_q = 1'b0;

  always @(negedge clk) begin
    if (sclk_a && !sclk_a_q) bits_a.push_back(sdo_a);
    if (sclk_b && !sclk_b_q) bits_b.push_back(sdo_b);
    if (sclk_c && !sclk_c_q) bits_c.push_back(sdo_c);
    if (done_a) done_cyc_a.push_back(cyc);
    if (done_b) done_cyc_b.push_back(cyc);
    if (done_c) done_cyc_c.push_back(cyc);
    sclk_a_q = sclk_a;
    sclk_b_q = sclk_b;
    sclk_c_q = sclk_c;
  end

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pack8(input logic q[$], input int first);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], q[first+i]};
    return v;
  endfunction

  typedef struct {
    int         inst;  // 0 = u_a, 1 = u_d
    int         off;   // cycle offset from the load cycle T
    logic [4:0] exp;   // {sclk, sdo, pen, ready, done}
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  function automatic logic [4:0] sample(input int inst);
    if (inst == 0) return {sclk_a, sdo_a, pen_a, ready_a, done_a};
    return {sclk_d, sdo_d, pen_d, ready_d, done_d};
  endfunction

  task automatic run_table(input int inst, input int ncyc);
    for (int off = 1; off <= ncyc; off++) begin
      step();
      if (off == 1) begin
        load_a = 1'b0;
        load_d = 1'b0;
      end
      for (int v = 0; v < NV; v++)
        if (tbl[v].inst == inst && tbl[v].off == off)
          check($sformatf("vec i%0d T+%0d", inst, off), 32'(sample(inst)), 32'(tbl[v].exp));
    end
  endtask

  int t0, c0, n0;
  bit got;

  initial begin
    // 8'hA5 MSB-first = 1,0,1,0,0,1,0,1; bit k spans T+1+4k .. T+4+4k, sclk high in its last two cycles
    tbl = '{
      '{0, 1, 5'b01000}, '{0, 3, 5'b11000}, '{0, 4, 5'b11000}, '{0, 5, 5'b00000},
      '{0, 7, 5'b10000}, '{0, 9, 5'b01000}, '{0, 13, 5'b00000}, '{0, 17, 5'b00000},
      '{0, 21, 5'b01000}, '{0, 25, 5'b00000}, '{0, 29, 5'b01000}, '{0, 32, 5'b11000},
      '{0, 33, 5'b00100}, '{0, 36, 5'b00100}, '{0, 37, 5'b00011}, '{0, 38, 5'b00010},
      '{1, 1, 5'b01000}, '{1, 2, 5'b11000}, '{1, 3, 5'b00100}, '{1, 4, 5'b00100},
      '{1, 5, 5'b00011}, '{1, 6, 5'b00010}
    };
    rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
    load_a = 0; load_b = 0; load_c = 0; load_d = 0;
    pdata_a = '0; pdata_b = '0; pdata_c = 8'h5A; pdata_d = '0;
    step(); step(); step();

    // Reset release and clear sequence
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    c0 = cyc;
    check("reset outs", 32'({sclk_a, sdo_a, pen_a, ready_a, done_a}), 32'h0);
    check("reset clr_n", 32'(clr_n_a), 32'h0);
    step(); step(); step();
    check("clear clr_n R+3", 32'(clr_n_a), 32'h0);
    check("clear ready R+3", 32'(ready_a), 32'h0);
    step();
    check("clear clr_n R+4", 32'(clr_n_a), 32'h1);
    check("idle ready R+4", 32'(ready_a), 32'h1);
    $display("[TB] clear sequence checked at cycle %0d", cyc);

    // Frame 1: 8'hA5 MSB first, table-driven
    step();
    bits_a.delete(); done_cyc_a.delete();
    pdata_a = 8'hA5; load_a = 1;
    t0 = cyc;
    run_table(0, 38);
    check("a1 nbits", 32'(bits_a.size()), 32'd8);
    check("a1 bits", 32'(pack8(bits_a, 0)), 32'hA5);
    check("a1 ndone", 32'(done_cyc_a.size()), 32'd1);
    $display("[TB] frame u_a pdata=a5 started at cycle %0d", t0);

    // Pending request mid-frame with new pdata; pdata change in frame 2 ignored
    bits_a.delete(); done_cyc_a.delete();
    pdata_a = 8'hA5; load_a = 1;
    t0 = cyc;
    for (int off = 1; off <= 75; off++) begin
      step();
      if (off == 1) load_a = 0;
      if (off == 5) begin pdata_a = 8'h3C; load_a = 1; end
      if (off == 6) load_a = 0;
      if (off == 37) begin
        check("pend done T+37", 32'(done_a), 32'h1);
        check("pend ready T+37", 32'(ready_a), 32'h0);
      end
      if (off == 38) check("pend ready T+38", 32'(ready_a), 32'h0);
      if (off == 40) pdata_a = 8'hFF;
    end
    check("pend ndone", 32'(done_cyc_a.size()), 32'd2);
    if (done_cyc_a.size() == 2) begin
      check("pend done1 cyc", 32'(done_cyc_a[0] - t0), 32'd37);
      check("pend done2 cyc", 32'(done_cyc_a[1] - t0), 32'd74);
    end
    check("pend nbits", 32'(bits_a.size()), 32'd16);
    check("pend bits f1", 32'(pack8(bits_a, 0)), 32'hA5);
    check("pend bits f2", 32'(pack8(bits_a, 8)), 32'h3C);
    $display("[TB] pending frames u_a started at cycle %0d", t0);

    // Reset mid-shift: outputs cleared, no done, then clear/idle and a normal frame
    step();
    done_cyc_a.delete();
    pdata_a = 8'hA5; load_a = 1;
    t0 = cyc;
    for (int off = 1; off <= 12; off++) begin
      step();
      if (off == 1) load_a = 0;
    end
    check("midrst pre sclk", 32'({sclk_a, sdo_a}), 32'h3);
    rst_a = 1;
    step();
    check("midrst outs", 32'({sclk_a, sdo_a, pen_a, ready_a, done_a}), 32'h0);
    check("midrst clr_n", 32'(clr_n_a), 32'h0);
    rst_a = 0;
    step(); step(); step();
    check("midrst clr_n +3", 32'(clr_n_a), 32'h0);
    step();
    check("midrst clr_n +4", 32'(clr_n_a), 32'h1);
    check("midrst ready +4", 32'(ready_a), 32'h1);
    for (int i = 0; i < 30; i++) step();
    check("midrst no done", 32'(done_cyc_a.size()), 32'd0);
    bits_a.delete();
    pdata_a = 8'hA5; load_a = 1;
    t0 = cyc;
    run_table(0, 38);
    check("post rst bits", 32'(pack8(bits_a, 0)), 32'hA5);
    check("post rst done", 32'(done_cyc_a.size()), 32'd1);
    $display("[TB] mid-frame reset u_a, recovery frame at cycle %0d", t0);

    // LSB first: 8'h01 -> first bit 1, rest 0
    bits_b.delete(); done_cyc_b.delete();
    pdata_b = 8'h01; load_b = 1;
    t0 = cyc;
    step();
    load_b = 0;
    for (int i = 0; i < 37; i++) step();
    check("lsb nbits", 32'(bits_b.size()), 32'd8);
    check("lsb bits", 32'(pack8(bits_b, 0)), 32'h80);
    check("lsb done", 32'(done_cyc_b.size() == 1 ? done_cyc_b[0] - t0 : -1), 32'd37);
    $display("[TB] frame u_b pdata=01 started at cycle %0d", t0);

    // Width 1, DIV 1
    pdata_d = 1'b1; load_d = 1;
    t0 = cyc;
    run_table(1, 6);
    $display("[TB] frame u_d pdata=1 started at cycle %0d", t0);

    // Auto-refresh: first frame fires 10 idle cycles after clear, then every 47 cycles
    check("ar ndone", 32'(done_cyc_c.size() >= 3), 32'h1);
    if (done_cyc_c.size() >= 3) begin
      check("ar first done", 32'(done_cyc_c[0] - c0), 32'd50);
      check("ar gap1", 32'(done_cyc_c[1] - done_cyc_c[0]), 32'd47);
      check("ar gap2", 32'(done_cyc_c[2] - done_cyc_c[1]), 32'd47);
    end
    check("ar bits f1", 32'(pack8(bits_c, 0)), 32'h5A);
    pdata_c = 8'hC3;
    n0 = done_cyc_c.size();
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (done_cyc_c.size() >= n0 + 2) got = 1;
    end
    check("ar wait", 32'(got), 32'h1);
    check("ar bits new", 32'(pack8(bits_c, bits_c.size() - 8)), 32'hC3);
    check("ar load never", 32'(load_c), 32'h0);
    $display("[TB] auto-refresh u_c observed %0d frames", done_cyc_c.size());

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/serial_shift_driver.md
Name: serial_shift_driver

Overview:
- Parametrised serial shift-out engine for the board's 74HC595-style chains (LED bar, 7-seg panel).
- Successor to the fixed-width, free-running shift register: adds width/clock-divide/bit-order parameters, a clear sequence, a load/ready handshake with one pending request, a done pulse and optional auto-refresh.
- Sits between display data producers (game logic, switches) and the board pins: sclk/sdo/pen/clr_n map to *_CLK/*_DO/*_PEN/*_CLR.

Parameters:
WIDTH, 16, number of bits shifted per frame (>=1)
DIV, 4, clk cycles per sclk half-period (>=1)
LSB_FIRST, 0, 0 = pdata[WIDTH-1] shifted first; 1 = pdata[0] first
AUTO_REFRESH, 1, 1 = restart a frame with current pdata after REFRESH_GAP idle cycles
REFRESH_GAP, 256, idle cycles before auto-refresh (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
pdata  in  WIDTH  parallel frame data
load  in  1  frame request, sampled each cycle
ready  out  1  high in IDLE with no pending request
done  out  1  one-cycle pulse at frame completion
sclk  out  1  serial shift clock
sdo  out  1  serial data
pen  out  1  latch enable, high during LATCH
clr_n  out  1  chain clear, active-low

Behaviour:
- All outputs registered. Counters sized with $clog2 of their ranges.
- While rst=1: state=CLEAR, counters=0, sclk=0, sdo=0, pen=0, clr_n=0, ready=0, done=0, pending=0. Applies mid-frame too: the frame is abandoned, no done.
- CLEAR: clr_n=0 for 2*DIV cycles after rst falls, then clr_n=1, go IDLE. Never re-entered except via rst.
- IDLE: ready=1 unless pending. Start condition: load=1 or pending=1 or (AUTO_REFRESH and idle counter reaches REFRESH_GAP-1). On start in cycle T: shadow<=pdata, pending<=0, ready<=0, enter SHIFT.
- SHIFT: bit k (k=0..WIDTH-1) occupies 2*DIV cycles starting at T+1+k*2*DIV. sdo = shadow bit (WIDTH-1-k if LSB_FIRST=0, k otherwise) for the whole bit period. sclk=0 for the first DIV cycles, 1 for the second DIV cycles. Exactly WIDTH rising sclk edges, each mid-bit.
- LATCH: cycles T+1+WIDTH*2*DIV for 2*DIV cycles; pen=1, sclk=0, sdo=0.
- done=1 for exactly cycle T+1+(WIDTH+1)*2*DIV; state returns to IDLE that cycle. The idle counter resets to 0.
- load while not in IDLE (SHIFT/LATCH/CLEAR): sets pending (one deep; further loads merge). pdata is sampled at the actual start, not at request.
- Frame start in the done cycle: if pending=1, or load=1 in the done cycle, the next frame starts on the cycle after done, with no ready gap.
- load in IDLE with auto-refresh firing the same cycle: a single frame starts.
- pdata changes during SHIFT have no effect on the current frame.

Test Plan:
- WIDTH=8, DIV=2, LSB_FIRST=0, AUTO_REFRESH=0; rst for 3 cycles, then load=1 with pdata=8'hA5 at T -> clr_n low for 4 cycles after reset; sdo on 8 sclk rises = 1,0,1,0,0,1,0,1; pen high for cycles T+33..T+36; done only at T+37; ready=1 from T+37 onward.
- Same config, LSB_FIRST=1, pdata=8'h01 -> sdo=1 at the first sclk rise, 0 at the remaining seven.
- load pulsed at T+5 during a frame with pdata changed to 8'h3C -> first frame unchanged; second frame starts at T+38 shifting 8'h3C; ready stays 0 between frames.
- AUTO_REFRESH=1, REFRESH_GAP=10, load never asserted after reset -> frames repeat with done pulses 10+1+36 cycles apart, each shifting current pdata.
- rst asserted at T+12 mid-SHIFT -> next cycle sclk=0, sdo=0, pen=0, clr_n=0, ready=0; no done pulse; after release, a CLEAR then IDLE sequence is followed by normal frames.
- WIDTH=1, DIV=1 -> single sclk rise at T+2; pen at T+3..T+4; done at T+5.
